// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pixel types and default display geometry
package video_pkg;

  localparam int DEF_RES_X      = 400;
  localparam int DEF_RES_Y      = 300;
  localparam int DEF_PAL_LEN    = 256;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    rgb444_t rgb;
    logic    sof;
    logic    eol;
  } pixel_beat_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - small synchronous FIFO of pixel beats
// Storage is not reset; only pointers and count are, so a reset empties it at once.
module pixel_fifo
  import video_pkg::*;
#(
  parameter int  DEPTH = DEF_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  pixel_beat_t   push_data_i,
  input  logic          pop_i,
  output pixel_beat_t   head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  pixel_beat_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - indexed framebuffer + RGB444 palette streamed out in raster order
// Reads are issued against FIFO credits, so the 2-stage RAM pipeline never stalls.
module fb_scanout
  import video_pkg::*;
#(
  parameter int  RESOLUTION_X   = DEF_RES_X,
  parameter int  RESOLUTION_Y   = DEF_RES_Y,
  parameter int  PALETTE_LENGTH = DEF_PAL_LEN,
  parameter int  FIFO_DEPTH     = DEF_FIFO_DEPTH,
  localparam int XW             = $clog2(RESOLUTION_X),
  localparam int YW             = $clog2(RESOLUTION_Y),
  localparam int IW             = $clog2(PALETTE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fb_wr_en,
  input  logic [XW-1:0] fb_wr_pxl_x,
  input  logic [YW-1:0] fb_wr_pxl_y,
  input  logic [IW-1:0] fb_wr_pxl_value,
  input  logic          pal_wr_en,
  input  logic [IW-1:0] pal_wr_index,
  input  logic [11:0]   pal_wr_color,
  output logic          pxl_valid,
  input  logic          pxl_ready,
  output logic [11:0]   pxl_rgb,
  output logic          pxl_sof,
  output logic          pxl_eol
);

  localparam int NPIX  = RESOLUTION_X * RESOLUTION_Y;
  localparam int AW    = $clog2(NPIX);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 2;

  logic [IW-1:0] fb_mem  [NPIX];
  rgb444_t       pal_mem [PALETTE_LENGTH];

  logic [XW-1:0]  rd_x_q, rd_x_d;
  logic [YW-1:0]  rd_y_q, rd_y_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic           s1_valid_q, s1_sof_q, s1_eol_q;
  logic           s2_valid_q, s2_sof_q, s2_eol_q;
  logic [IW-1:0]  s1_idx_q;
  rgb444_t        s2_rgb_q;

  logic           fb_wr_ok;
  logic [AW-1:0]  fb_wr_addr;
  logic [FCW-1:0] fifo_count;
  logic           fifo_empty, fifo_full;
  pixel_beat_t    fifo_head, push_beat;
  logic           pop, issue;
  logic [CW-1:0]  credits_used;

  always_comb begin
    fb_wr_ok   = fb_wr_en && (int'(fb_wr_pxl_x) < RESOLUTION_X)
                          && (int'(fb_wr_pxl_y) < RESOLUTION_Y);
    fb_wr_addr = AW'(int'(fb_wr_pxl_y) * RESOLUTION_X + int'(fb_wr_pxl_x));
  end

  // A pop in this cycle returns its slot before the issue decision.
  assign pop          = pxl_valid && pxl_ready;
  assign credits_used = CW'(fifo_count) + CW'(s1_valid_q) + CW'(s2_valid_q) - CW'(pop);
  assign issue        = !(fifo_full && !pop) && (credits_used < CW'(FIFO_DEPTH));

  always_comb begin
    rd_x_d    = rd_x_q;
    rd_y_d    = rd_y_q;
    rd_addr_d = rd_addr_q;
    if (issue) begin
      if (rd_x_q == XW'(RESOLUTION_X - 1)) begin
        rd_x_d = '0;
        if (rd_y_q == YW'(RESOLUTION_Y - 1)) begin
          rd_y_d    = '0;
          rd_addr_d = '0;
        end else begin
          rd_y_d    = rd_y_q + YW'(1);
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end else begin
        rd_x_d    = rd_x_q + XW'(1);
        rd_addr_d = rd_addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sof_q   <= 1'b0;
      s2_eol_q   <= 1'b0;
    end else begin
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      rd_addr_q  <= rd_addr_d;
      s1_valid_q <= issue;
      s1_sof_q   <= issue && (rd_x_q == '0) && (rd_y_q == '0);
      s1_eol_q   <= issue && (rd_x_q == XW'(RESOLUTION_X - 1));
      s2_valid_q <= s1_valid_q;
      s2_sof_q   <= s1_sof_q;
      s2_eol_q   <= s1_eol_q;
    end
  end

  // Read-first RAMs: a same-cycle write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (fb_wr_ok) fb_mem[fb_wr_addr] <= fb_wr_pxl_value;
    if (issue)    s1_idx_q <= fb_mem[rd_addr_q];
  end

  always_ff @(posedge clk) begin
    if (pal_wr_en) pal_mem[pal_wr_index] <= pal_wr_color;
    s2_rgb_q <= pal_mem[s1_idx_q];
  end

  assign push_beat = {s2_rgb_q, s2_sof_q, s2_eol_q};

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (s2_valid_q),
    .push_data_i (push_beat),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign pxl_valid = !fifo_empty;
  assign pxl_rgb   = pxl_valid ? fifo_head.rgb : 12'h000;
  assign pxl_sof   = pxl_valid && fifo_head.sof;
  assign pxl_eol   = pxl_valid && fifo_head.eol;

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - raster-order scoreboard bench for fb_scanout
module tb_fb_scanout;
  import video_pkg::*;

  localparam int RX = 400;
  localparam int RY = 12;
  localparam int NP = RX * RY;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fb_wr_en = 1'b0;
  logic [8:0]  fb_wr_pxl_x = '0;
  logic [3:0]  fb_wr_pxl_y = '0;
  logic [7:0]  fb_wr_pxl_value = '0;
  logic        pal_wr_en = 1'b0;
  logic [7:0]  pal_wr_index = '0;
  logic [11:0] pal_wr_color = '0;
  logic        pxl_valid;
  logic        pxl_ready = 1'b0;
  logic [11:0] pxl_rgb;
  logic        pxl_sof;
  logic        pxl_eol;

  fb_scanout #(
    .RESOLUTION_X   (RX),
    .RESOLUTION_Y   (RY),
    .PALETTE_LENGTH (256),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fb_wr_en        (fb_wr_en),
    .fb_wr_pxl_x     (fb_wr_pxl_x),
    .fb_wr_pxl_y     (fb_wr_pxl_y),
    .fb_wr_pxl_value (fb_wr_pxl_value),
    .pal_wr_en       (pal_wr_en),
    .pal_wr_index    (pal_wr_index),
    .pal_wr_color    (pal_wr_color),
    .pxl_valid       (pxl_valid),
    .pxl_ready       (pxl_ready),
    .pxl_rgb         (pxl_rgb),
    .pxl_sof         (pxl_sof),
    .pxl_eol         (pxl_eol)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference image: palette and framebuffer contents as the bench intends them.
  logic [11:0] pal_m [256];
  logic [7:0]  fb_m  [NP];

  function automatic logic [13:0] exp_beat(input int x, input int y);
    logic [11:0] c;
    c = pal_m[fb_m[y * RX + x]];
    return {c, (x == 0 && y == 0), (x == RX - 1)};
  endfunction

  // Scoreboard: every accepted beat must be the next raster position of the image.
  int          mx = 0, my = 0, beats = 0, sof_seen = 0;
  logic        held = 1'b0;
  logic [13:0] held_beat = '0;
  logic [13:0] cap [512];

  always @(negedge clk) begin
    if (reset) begin
      mx = 0; my = 0; beats = 0; sof_seen = 0; held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", {31'b0, pxl_valid}, 32'd1);
        chk("hold_stable", {18'b0, pxl_rgb, pxl_sof, pxl_eol}, {18'b0, held_beat});
      end
      chk("fifo_le_depth", {31'b0, (dut.fifo_count <= 3'd4)}, 32'd1);
      if (pxl_valid && pxl_ready) begin
        chk("beat", {18'b0, pxl_rgb, pxl_sof, pxl_eol}, {18'b0, exp_beat(mx, my)});
        if (beats < 512) cap[beats] = {pxl_rgb, pxl_sof, pxl_eol};
        if (pxl_sof) sof_seen++;
        beats++;
        if (mx == RX - 1) begin
          mx = 0;
          my = (my == RY - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end
      held      = pxl_valid && !pxl_ready;
      held_beat = {pxl_rgb, pxl_sof, pxl_eol};
    end
  end

  task automatic wait_beats(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (beats < target && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk(name, {31'b0, (beats >= target)}, 32'd1);
  endtask

  task automatic fb_write(input int x, input int y, input int v);
    @(posedge clk); #1;
    fb_wr_en        = 1'b1;
    fb_wr_pxl_x     = 9'(x);
    fb_wr_pxl_y     = 4'(y);
    fb_wr_pxl_value = 8'(v);
  endtask

  initial begin
    int b0, c, start;

    for (int i = 0; i < 256; i++) pal_m[i] = 12'((i * 37 + 11) & 12'hFFF);
    pal_m[5] = 12'hF00;
    pal_m[7] = 12'h0A0;
    for (int y = 0; y < RY; y++)
      for (int x = 0; x < RX; x++) fb_m[y * RX + x] = 8'((x + 3 * y) % 256);
    fb_m[0]      = 8'd5;
    fb_m[RX - 1] = 8'd7;

    #1 reset = 1'b1;
    #1;
    chk("reset_valid", {31'b0, pxl_valid}, 32'd0);
    chk("reset_rgb",   {20'b0, pxl_rgb},   32'd0);
    chk("reset_sof",   {31'b0, pxl_sof},   32'd0);
    chk("reset_eol",   {31'b0, pxl_eol},   32'd0);

    // Load palette and image while held in reset so nothing is scanned yet.
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      pal_wr_en = 1'b1; pal_wr_index = 8'(i); pal_wr_color = pal_m[i];
    end
    @(posedge clk); #1;
    pal_wr_en = 1'b0;
    for (int y = 0; y < RY; y++)
      for (int x = 0; x < RX; x++) fb_write(x, y, fb_m[y * RX + x]);
    // Out-of-range writes; the reference image deliberately ignores them.
    fb_write(450, 0, 9);
    fb_write(450, 2, 9);
    fb_write(10, 12, 9);
    fb_write(0, 15, 9);
    @(posedge clk); #1;
    fb_wr_en = 1'b0;
    chk("still_idle", {31'b0, pxl_valid}, 32'd0);

    // Full-speed scanout of the first frame and into the second.
    reset = 1'b0;
    pxl_ready = 1'b1;
    wait_beats(10, 100, "first_beats");
    b0 = beats;
    repeat (100) @(posedge clk);
    #1;
    chk("throughput_100", beats - b0, 32'd100);
    wait_beats(402, 1000, "line0_done");
    chk("b0_rgb",   {20'b0, cap[0][13:2]},   32'hF00);
    chk("b0_sof",   {31'b0, cap[0][1]},      32'd1);
    chk("b0_eol",   {31'b0, cap[0][0]},      32'd0);
    chk("b399_rgb", {20'b0, cap[399][13:2]}, 32'h0A0);
    chk("b399_eol", {31'b0, cap[399][0]},    32'd1);
    chk("b399_sof", {31'b0, cap[399][1]},    32'd0);
    chk("b400_rgb", {20'b0, cap[400][13:2]}, 32'h07A);
    chk("b400_eol", {31'b0, cap[400][0]},    32'd0);
    chk("b401_rgb", {20'b0, cap[401][13:2]}, 32'h09F);

    // Mid-line stall of 20 cycles in the second frame.
    wait_beats(NP + 150, 6000, "reach_stall");
    pxl_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("stall_valid", {31'b0, pxl_valid}, 32'd1);
    chk("stall_rgb", {20'b0, pxl_rgb}, {20'b0, exp_beat(mx, my) >> 2});
    pxl_ready = 1'b1;

    // Random backpressure across two frames.
    start = beats;
    c = 0;
    while (beats < start + 2 * NP && c < 40000) begin
      @(posedge clk); #1;
      pxl_ready = 1'($urandom_range(0, 1));
      c++;
    end
    chk("random_done", {31'b0, (beats >= start + 2 * NP)}, 32'd1);
    chk("sof_count", sof_seen, (beats + NP - 1) / NP);

    // Reset while pixel (100,5) is next in line.
    pxl_ready = 1'b1;
    c = 0;
    while (!(mx == 100 && my == 5) && c < 8000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reach_100_5", {31'b0, (mx == 100 && my == 5)}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_valid", {31'b0, pxl_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_beats(2, 100, "restart_beats");
    chk("restart_rgb", {20'b0, cap[0][13:2]}, 32'hF00);
    chk("restart_sof", {31'b0, cap[0][1]},    32'd1);
    chk("restart_b1",  {20'b0, cap[1][13:2]}, {20'b0, pal_m[fb_m[1]]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Receiving end of the framebuffer write interface driven by the processor memory stage.
- Stores 8-bit palette indices written at (x, y) and holds a 256-entry RGB444 palette.
- Streams the frame continuously in raster order as RGB pixels over a valid/ready stream to the video timing/output block.
- Sits between the processor datapath and the display pipeline.

Parameters:
- RESOLUTION_X, 400, pixels per line.
- RESOLUTION_Y, 300, lines per frame.
- PALETTE_LENGTH, 256, palette entries; index width is clog2(PALETTE_LENGTH).
- FIFO_DEPTH, 4, output pixel FIFO entries; power of two, at least 4.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- fb_wr_en  in  1  pixel write strobe.
- fb_wr_pxl_x  in  clog2(RESOLUTION_X)  write column.
- fb_wr_pxl_y  in  clog2(RESOLUTION_Y)  write row.
- fb_wr_pxl_value  in  clog2(PALETTE_LENGTH)  palette index to store.
- pal_wr_en  in  1  palette entry write strobe.
- pal_wr_index  in  clog2(PALETTE_LENGTH)  palette entry address.
- pal_wr_color  in  12  RGB444 colour, {r[3:0], g[3:0], b[3:0]}.
- pxl_valid  out  1  output pixel available.
- pxl_ready  in  1  downstream accepts the pixel.
- pxl_rgb  out  12  pixel colour.
- pxl_sof  out  1  pixel is (0,0), start of frame.
- pxl_eol  out  1  pixel is the last of its line.

Behaviour:
- Reset (async assert): pxl_valid=0, pxl_rgb=0, pxl_sof=0, pxl_eol=0.
  - Read counters rd_x=0 and rd_y=0; in-flight count 0; FIFO empty.
  - Framebuffer and palette RAM contents are not cleared. Contents at power-up are undefined; the bench writes them before checking.
  - Reset release is used synchronously.
  - Reset mid-frame discards all in-flight and queued pixels. The next frame restarts at (0,0) with sof.
- Write port:
  - When fb_wr_en=1, x<RESOLUTION_X and y<RESOLUTION_Y, store value at addr = y*RESOLUTION_X + x.
  - A write with an out-of-range x or y is dropped silently.
  - Palette writes are unconditional: the index width covers all entries.
- RAMs are synchronous and single-cycle. A same-address read and write in the same cycle returns the old data (read-first).
- Read pipeline:
  - S0 issues a framebuffer read at (rd_x, rd_y).
  - S1 uses the returned index to read the palette.
  - S2 pushes {rgb, sof, eol} into the FIFO.
  - sof and eol are computed in S0 and carried alongside the data.
  - Latency from issue to FIFO write is 2 cycles.
- Issue rule (credit-based, no stalls inside the pipeline):
  - Issue when fifo_count + inflight + 1 <= FIFO_DEPTH.
  - inflight counts S1+S2 occupancy (0..2).
  - In the same cycle, a pop frees a slot before the issue decision is made.
- Counter advance on issue:
  - rd_x increments.
  - At RESOLUTION_X-1, rd_x wraps to 0 and rd_y increments.
  - At (RESOLUTION_X-1, RESOLUTION_Y-1), both wrap to 0, giving a continuous frame loop.
- Output handshake:
  - pxl_rgb, pxl_sof and pxl_eol are driven from the FIFO head.
  - pxl_valid = !fifo_empty.
  - A pop occurs when pxl_valid && pxl_ready.
  - While pxl_valid=1, the outputs stay stable until accepted.
- Simultaneous push and pop on a full FIFO cannot happen, because the credit rule prevents overflow.
- A push to the FIFO while it is empty shows up on pxl_valid in the next cycle.
- Steady-state throughput is 1 pixel/cycle when pxl_ready is held high.
- There is no tearing protection. A pixel written during scanout appears in this frame only if it is written before its read is issued.

Decomposition:
- Shared package video_pkg:
  - rgb444_t packed struct {r, g, b}.
  - Default resolution and palette-length constants.
  - pixel_beat_t {rgb444_t rgb; logic sof; logic eol}.
- Sub-module pixel_fifo:
  - Synchronous FIFO of pixel_beat_t, depth FIFO_DEPTH.
  - Outputs count, empty and full.
  - Asynchronous reset.
- Framebuffer and palette RAMs are inferred inline in fb_scanout.

Test Plan:
- Reset then write palette[5]=0xF00 and fb(0,0)=5, holding pxl_ready=1 → the first beat after the pipeline fills has rgb=0xF00, sof=1, eol=0.
- Write fb(399,0)=7 and palette[7]=0x0A0, with pxl_ready=1 → beat number 400 has rgb=0x0A0, eol=1. Exactly 1 sof per 120000 beats, and line 0 wraps to line 1.
- Write with fb_wr_pxl_x=450 (or y=310) and value 9 → no framebuffer location changes; a full-frame readback matches the pre-write image.
- Hold pxl_ready=0 for 20 cycles mid-line → pxl_valid stays 1 with pxl_rgb stable, no beat is lost or duplicated, and the sequence resumes in exact raster order.
- Toggle pxl_ready 1/0 at random for 2 frames → the beat sequence equals the reference raster model and the FIFO never overflows (count ≤ 4).
- Assert reset at pixel (100,50) for 3 cycles → pxl_valid=0 immediately (asynchronously), and the next accepted beat is (0,0) with sof=1.
